audio_frame_buffer: RTL and testbench

- Upstream neighbour of the 16-point FFT processor.
- Collects a stream of 24-bit signed audio samples from the codec/ADC interface into a 16-sample frame.
- Presents the frame in time order on t0..t15 and pulses new_t only when the FFT reports idle (fft_done=1).
- Samples arriving while a full frame waits for the FFT are dropped and counted, because the codec cannot be back-pressured.

---
 rtl/audio_frame_buffer.sv | 186 ++++++++++++++++++
 tb/tb_audio_frame_buffer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_frame_buffer.sv
// Collects decimated 24-bit audio samples into a 16-sample frame and hands the
// frame to the downstream FFT when it reports idle. Samples that arrive while a frame is waiting are dropped and counted.
module audio_frame_buffer #(
    parameter int unsigned DECIMATE = 1,
    parameter int unsigned DROP_W   = 8,
    parameter int unsigned GUARD    = 2
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_sample_valid,
    input  logic [23:0]       i_sample,
    input  logic              i_fft_done,
    output logic [23:0]       o_t0,
    output logic [23:0]       o_t1,
    output logic [23:0]       o_t2,
    output logic [23:0]       o_t3,
    output logic [23:0]       o_t4,
    output logic [23:0]       o_t5,
    output logic [23:0]       o_t6,
    output logic [23:0]       o_t7,
    output logic [23:0]       o_t8,
    output logic [23:0]       o_t9,
    output logic [23:0]       o_t10,
    output logic [23:0]       o_t11,
    output logic [23:0]       o_t12,
    output logic [23:0]       o_t13,
    output logic [23:0]       o_t14,
    output logic [23:0]       o_t15,
    output logic              o_new_t,
    output logic              o_frame_busy,
    output logic              o_overrun,
    output logic [DROP_W-1:0] o_drop_cnt
);

    localparam int unsigned SAMPLE_W = 24;
    localparam int unsigned N_SAMP   = 16;
    localparam int unsigned IDX_W    = 4;
    localparam int unsigned DEC_W    = 8;
    localparam int unsigned GRD_W    = $clog2(GUARD + 1);

    typedef enum logic [0:0] {
        S_FILL = 1'b0,
        S_FULL = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IDX_W-1:0]    r_wr_idx;
    logic [IDX_W-1:0]    w_wr_idx_nxt;
    logic [DEC_W-1:0]    r_decim_cnt;
    logic [GRD_W-1:0]    r_guard_cnt;
    logic [SAMPLE_W-1:0] r_cap [N_SAMP];
    logic [SAMPLE_W-1:0] r_t   [N_SAMP];
    logic                r_new_t;
    logic                r_frame_busy;
    logic                r_overrun;
    logic [DROP_W-1:0]   r_drop_cnt;

    logic                w_accept;
    logic                w_issue;
    logic                w_cap_we;
    logic                w_drop;

    assign w_accept = i_sample_valid && (r_decim_cnt == '0);

    // State register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, capture write enable, issue and drop decisions
    always_comb begin
        w_state_nxt  = r_state;
        w_wr_idx_nxt = r_wr_idx;
        w_issue      = 1'b0;
        w_cap_we     = 1'b0;
        w_drop       = 1'b0;
        case (r_state)
            S_FILL: begin
                if (w_accept) begin
                    w_cap_we = 1'b1;
                    if (r_wr_idx == IDX_W'(N_SAMP - 1)) begin
                        w_state_nxt  = S_FULL;
                        w_wr_idx_nxt = '0;
                    end else begin
                        w_wr_idx_nxt = r_wr_idx + IDX_W'(1);
                    end
                end
            end
            S_FULL: begin
                if (i_fft_done && (r_guard_cnt == '0)) begin
                    w_issue     = 1'b1;
                    w_state_nxt = S_FILL;
                    // wr_idx is 0 here, so a coincident sample opens the next frame
                    if (w_accept) begin
                        w_cap_we     = 1'b1;
                        w_wr_idx_nxt = IDX_W'(1);
                    end
                end else if (w_accept) begin
                    w_drop = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_FILL;
            end
        endcase
    end

    // Control counters and status flags
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wr_idx     <= '0;
            r_decim_cnt  <= '0;
            r_guard_cnt  <= '0;
            r_new_t      <= 1'b0;
            r_frame_busy <= 1'b0;
            r_overrun    <= 1'b0;
            r_drop_cnt   <= '0;
        end else begin
            r_wr_idx     <= w_wr_idx_nxt;
            r_new_t      <= w_issue;
            r_frame_busy <= (w_state_nxt == S_FULL);
            if (i_sample_valid) begin
                r_decim_cnt <= (r_decim_cnt == DEC_W'(DECIMATE - 1)) ? '0
                                                                     : r_decim_cnt + DEC_W'(1);
            end
            // Guard masks the stale fft_done still high right after an issue
            if (w_issue) begin
                r_guard_cnt <= GRD_W'(GUARD);
            end else if (r_guard_cnt != '0) begin
                r_guard_cnt <= r_guard_cnt - GRD_W'(1);
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
                if (r_drop_cnt != '1) begin
                    r_drop_cnt <= r_drop_cnt + DROP_W'(1);
                end
            end
        end
    end

    // Capture buffer and presented frame
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int k = 0; k < int'(N_SAMP); k++) begin
                r_cap[k] <= '0;
                r_t[k]   <= '0;
            end
        end else begin
            if (w_cap_we) begin
                r_cap[r_wr_idx] <= i_sample;
            end
            if (w_issue) begin
                for (int k = 0; k < int'(N_SAMP); k++) begin
                    r_t[k] <= r_cap[k];
                end
            end
        end
    end

    assign o_t0         = r_t[0];
    assign o_t1         = r_t[1];
    assign o_t2         = r_t[2];
    assign o_t3         = r_t[3];
    assign o_t4         = r_t[4];
    assign o_t5         = r_t[5];
    assign o_t6         = r_t[6];
    assign o_t7         = r_t[7];
    assign o_t8         = r_t[8];
    assign o_t9         = r_t[9];
    assign o_t10        = r_t[10];
    assign o_t11        = r_t[11];
    assign o_t12        = r_t[12];
    assign o_t13        = r_t[13];
    assign o_t14        = r_t[14];
    assign o_t15        = r_t[15];
    assign o_new_t      = r_new_t;
    assign o_frame_busy = r_frame_busy;
    assign o_overrun    = r_overrun;
    assign o_drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_audio_frame_buffer.sv
// Directed bench for audio_frame_buffer: one default instance and one with
// DECIMATE=3, DROP_W=4; expected frames are queued as stimulus is driven.
module tb_audio_frame_buffer;

    typedef logic [15:0][23:0] frame_t;

    logic        clk;
    logic        rst_n;

    logic        a_valid, a_done, a_new_t, a_busy, a_overrun;
    logic [23:0] a_sample;
    logic [23:0] a_t [16];
    logic [7:0]  a_drop;

    logic        b_valid, b_done, b_new_t, b_busy, b_overrun;
    logic [23:0] b_sample;
    logic [23:0] b_t [16];
    logic [3:0]  b_drop;

    frame_t q_a[$];
    frame_t q_b[$];
    int     checks   = 0;
    int     failures = 0;

    audio_frame_buffer dut_a (
        .i_clk(clk), .i_reset_n(rst_n), .i_sample_valid(a_valid), .i_sample(a_sample),
        .i_fft_done(a_done),
        .o_t0(a_t[0]), .o_t1(a_t[1]), .o_t2(a_t[2]), .o_t3(a_t[3]),
        .o_t4(a_t[4]), .o_t5(a_t[5]), .o_t6(a_t[6]), .o_t7(a_t[7]),
        .o_t8(a_t[8]), .o_t9(a_t[9]), .o_t10(a_t[10]), .o_t11(a_t[11]),
        .o_t12(a_t[12]), .o_t13(a_t[13]), .o_t14(a_t[14]), .o_t15(a_t[15]),
        .o_new_t(a_new_t), .o_frame_busy(a_busy), .o_overrun(a_overrun), .o_drop_cnt(a_drop)
    );

    audio_frame_buffer #(.DECIMATE(3), .DROP_W(4), .GUARD(2)) dut_b (
        .i_clk(clk), .i_reset_n(rst_n), .i_sample_valid(b_valid), .i_sample(b_sample),
        .i_fft_done(b_done),
        .o_t0(b_t[0]), .o_t1(b_t[1]), .o_t2(b_t[2]), .o_t3(b_t[3]),
        .o_t4(b_t[4]), .o_t5(b_t[5]), .o_t6(b_t[6]), .o_t7(b_t[7]),
        .o_t8(b_t[8]), .o_t9(b_t[9]), .o_t10(b_t[10]), .o_t11(b_t[11]),
        .o_t12(b_t[12]), .o_t13(b_t[13]), .o_t14(b_t[14]), .o_t15(b_t[15]),
        .o_new_t(b_new_t), .o_frame_busy(b_busy), .o_overrun(b_overrun), .o_drop_cnt(b_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_frame(input string tag, input frame_t obs, input frame_t exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic frame_t pack_a();
        frame_t f;
        for (int k = 0; k < 16; k++) f[k] = a_t[k];
        return f;
    endfunction

    function automatic frame_t pack_b();
        frame_t f;
        for (int k = 0; k < 16; k++) f[k] = b_t[k];
        return f;
    endfunction

    // One clock; outputs sampled 1 time unit after the edge, every new_t scored
    task automatic step();
        @(posedge clk);
        #1;
        if (a_new_t) begin
            chk("a_new_t_expected", 32'(q_a.size() > 0), 32'd1);
            if (q_a.size() > 0) chk_frame("a_frame", pack_a(), q_a.pop_front());
        end
        if (b_new_t) begin
            chk("b_new_t_expected", 32'(q_b.size() > 0), 32'd1);
            if (q_b.size() > 0) chk_frame("b_frame", pack_b(), q_b.pop_front());
        end
    endtask

    initial begin
        frame_t f;
        rst_n    = 1'b0;
        a_valid  = 1'b0; a_done = 1'b0; a_sample = '0;
        b_valid  = 1'b0; b_done = 1'b0; b_sample = '0;
        f        = '0;

        // Reset state
        step(); step();
        chk("rst_new_t", 32'(a_new_t), 32'd0);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_overrun", 32'(a_overrun), 32'd0);
        chk("rst_drop", 32'(a_drop), 32'd0);
        chk("rst_t0", 32'(a_t[0]), 32'd0);
        chk("rst_t15", 32'(a_t[15]), 32'd0);
        rst_n = 1'b1;
        step();

        // 1: best-case latency with fft_done held high
        a_done = 1'b1;
        for (int i = 0; i < 16; i++) begin
            a_valid  = 1'b1;
            a_sample = 24'(32'h100 * (i + 1));
            f[i]     = 24'(32'h100 * (i + 1));
            if (i == 15) q_a.push_back(f);
            step();
        end
        a_valid = 1'b0;
        chk("t1_new_t_not_yet", 32'(a_new_t), 32'd0);
        chk("t1_busy_full", 32'(a_busy), 32'd1);
        step();
        chk("t1_new_t_pulse", 32'(a_new_t), 32'd1);
        chk("t1_t0", 32'(a_t[0]), 32'h000100);
        chk("t1_t15", 32'(a_t[15]), 32'h001000);
        step();
        chk("t1_new_t_one_cycle", 32'(a_new_t), 32'd0);
        chk("t1_overrun", 32'(a_overrun), 32'd0);
        chk("t1_busy_clear", 32'(a_busy), 32'd0);
        step(); step();

        // 2: frame waits with fft_done low; ten samples dropped
        a_done = 1'b0;
        for (int i = 0; i < 16; i++) begin
            a_valid  = 1'b1;
            a_sample = 24'(32'h200 + i);
            f[i]     = 24'(32'h200 + i);
            if (i == 15) q_a.push_back(f);
            step();
        end
        chk("t2_busy", 32'(a_busy), 32'd1);
        for (int i = 0; i < 10; i++) begin
            a_sample = 24'(32'hDEAD00 + i);
            step();
            chk("t2_no_issue", 32'(a_new_t), 32'd0);
        end
        a_valid = 1'b0;
        chk("t2_drop_cnt", 32'(a_drop), 32'd10);
        chk("t2_overrun", 32'(a_overrun), 32'd1);
        a_done = 1'b1;
        step();
        chk("t2_new_t", 32'(a_new_t), 32'd1);
        chk("t2_t0_original", 32'(a_t[0]), 32'h000200);
        step(); step(); step();

        // 3: continuous stream, issue-edge sample opens next frame
        for (int n = 0; n < 48; n++) begin
            a_valid   = 1'b1;
            a_sample  = 24'(32'h300 + n);
            f[n % 16] = 24'(32'h300 + n);
            if (n % 16 == 15) q_a.push_back(f);
            step();
            chk("t3_new_t_cadence", 32'(a_new_t), 32'((n == 16) || (n == 32)));
        end
        a_valid = 1'b0;
        step();
        chk("t3_last_new_t", 32'(a_new_t), 32'd1);
        chk("t3_last_t0", 32'(a_t[0]), 32'h000320);
        chk("t3_no_new_drops", 32'(a_drop), 32'd10);
        step(); step();

        // 5: reset mid-frame discards partial frame
        for (int i = 0; i < 9; i++) begin
            a_valid  = 1'b1;
            a_sample = 24'h000111;
            step();
        end
        a_valid = 1'b0;
        rst_n   = 1'b0;
        step();
        chk("t5_rst_drop", 32'(a_drop), 32'd0);
        chk("t5_rst_overrun", 32'(a_overrun), 32'd0);
        chk("t5_rst_t0", 32'(a_t[0]), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 16; i++) begin
            a_valid  = 1'b1;
            a_sample = 24'h7FFFFF;
            f[i]     = 24'h7FFFFF;
            if (i == 15) q_a.push_back(f);
            step();
            chk("t5_no_partial_issue", 32'(a_new_t), 32'd0);
        end
        a_valid = 1'b0;
        step();
        chk("t5_new_t", 32'(a_new_t), 32'd1);
        chk("t5_t15", 32'(a_t[15]), 32'h7FFFFF);
        chk("t5_drop_zero", 32'(a_drop), 32'd0);
        step(); step();

        // 4: DECIMATE=3 keeps every third strobe
        b_done = 1'b1;
        for (int i = 0; i < 48; i++) begin
            b_valid  = 1'b1;
            b_sample = 24'(i);
            if (i % 3 == 0) f[i / 3] = 24'(i);
            if (i == 45) q_b.push_back(f);
            step();
            chk("t4_new_t_timing", 32'(b_new_t), 32'(i == 46));
        end
        b_valid = 1'b0;
        chk("t4_t1", 32'(b_t[1]), 32'd3);
        chk("t4_t15", 32'(b_t[15]), 32'd45);
        chk("t4_no_drops", 32'(b_drop), 32'd0);
        step(); step(); step();

        // 6: DROP_W=4 counter saturates, overrun survives the issue
        b_done = 1'b0;
        for (int i = 0; i < 48; i++) begin
            b_valid  = 1'b1;
            b_sample = 24'(100 + i);
            if (i % 3 == 0) f[i / 3] = 24'(100 + i);
            if (i == 45) q_b.push_back(f);
            step();
        end
        for (int i = 0; i < 60; i++) begin
            b_sample = 24'(32'h5000 + i);
            step();
        end
        b_valid = 1'b0;
        chk("t6_busy", 32'(b_busy), 32'd1);
        chk("t6_drop_sat", 32'(b_drop), 32'd15);
        chk("t6_overrun", 32'(b_overrun), 32'd1);
        b_done = 1'b1;
        step();
        chk("t6_new_t", 32'(b_new_t), 32'd1);
        step(); step();
        chk("t6_overrun_sticky", 32'(b_overrun), 32'd1);
        chk("t6_drop_held", 32'(b_drop), 32'd15);

        chk("a_all_frames_issued", 32'(q_a.size()), 32'd0);
        chk("b_all_frames_issued", 32'(q_b.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
